sdu_mem_dump: RTL and testbench
===============================

SDU_MEM_DUMP -- requirements
Module: sdu_mem_dump

Interface
REQ-001 The block SHALL use one clock; reset is synchronous and active-high.
REQ-002 clk  input  1  system clock; all state changes on posedge clk.
REQ-003 rst  input  1  synchronous active-high reset.
REQ-004 start  input  1  dump request; sampled only in IDLE.
REQ-005 start_addr  input  32  first word address; only bits [9:0] used.
REQ-006 word_cnt  input  11  words to dump; 0 = no-op, values >1024 clamp to 1024.
REQ-007 addr_sdu  output  32  debug read address to data memory, {22'b0, ptr[9:0]}.
REQ-008 data_sdu  input  32  debug read data; combinational, valid in the same cycle as addr_sdu.
REQ-009 tx_data  output  8  ASCII byte to the UART transmitter.
REQ-010 tx_valid  output  1  tx_data valid.
REQ-011 tx_ready  input  1  transmitter accepts byte; handshake = tx_valid & tx_ready at posedge.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse at end of dump.

Function
REQ-014 FSM states SHALL be IDLE, LOAD, SEND, NL, DONE.
REQ-015 IDLE: on start with word_cnt!=0, capture ptr<=start_addr[9:0] and remaining<=min(word_cnt,1024), then go to LOAD; on start with word_cnt==0, go to DONE; otherwise stay.
REQ-016 LOAD: addr_sdu reflects the registered ptr, word_reg<=data_sdu, nib<=0, go to SEND; tx_valid=0.
REQ-017 SEND: tx_valid=1, tx_data=hex(word_reg nibble nib), MSB nibble first; on handshake nib+1; after the 8th handshake go to NL.
REQ-018 Hex mapping SHALL be 0-9 -> 0x30-0x39 and A-F -> 0x41-0x46 (uppercase).
REQ-019 NL: tx_valid=1, tx_data=0x0A; on handshake ptr<=ptr+1 mod 1024 and remaining<=remaining-1; if remaining was 1, go to DONE, else go to LOAD.
REQ-020 DONE: done=1 for exactly one cycle, then go to IDLE.
REQ-021 While tx_valid=1 and tx_ready=0, tx_data and tx_valid SHALL hold stable; no byte is dropped or duplicated.
REQ-022 start asserted while busy=1 SHALL be ignored and SHALL not be queued.
REQ-023 Address SHALL wrap 1023 -> 0 with no error indication.
REQ-024 Latency: start accepted at edge t gives LOAD in cycle t..t+1 and first tx_valid in cycle t+1..t+2; each word takes 9 handshakes plus 1 LOAD cycle.
REQ-025 Output bytes per dump SHALL equal 9 x min(word_cnt,1024).
REQ-026 addr_sdu SHALL be driven from the ptr register only (no combinational path from start/start_addr).

Reset
REQ-027 On rst, at the next edge: state=IDLE, busy=0, done=0, tx_valid=0, tx_data=0x00, ptr=0, remaining=0, nib=0, word_reg=0, addr_sdu=0.
REQ-028 rst mid-dump SHALL abort immediately with no done pulse; the following start SHALL behave as from power-up.
REQ-029 rst SHALL take priority over start in the same cycle.

Verification
REQ-030 mem[5]=0x1234ABCD, start_addr=5, word_cnt=1, tx_ready=1 -> bytes 31 32 33 34 41 42 43 44 0A, first tx_valid 2 cycles after start, done 1 cycle after the 0A handshake, busy low afterwards.
REQ-031 mem[1023]=0xFFFFFFFF, mem[0]=0, start_addr=1023, word_cnt=2 -> addr_sdu 1023 then 0; bytes 46x8 0A 30x8 0A.
REQ-032 Hold tx_ready low for 5 cycles mid-word, then random toggling -> tx_data stable while stalled; exact 9-byte sequence per word; no loss or duplication.
REQ-033 word_cnt=0 -> done pulse one cycle later, tx_valid never high; start pulsed during an active dump -> ignored, byte count unchanged.
REQ-034 rst asserted after 4th byte of a 3-word dump -> tx_valid=0, busy=0 next edge, no done; new dump start_addr=5, word_cnt=1 -> identical output to REQ-030.
REQ-035 word_cnt=2000, start_addr=0 -> exactly 9216 bytes, addresses 0..1023, single done pulse.

Source files
------------

// File: rtl/sdu_mem_dump_if.sv
// Bus bundle for the memory dump unit. It carries the start request, the
// debug read port into data memory, the UART byte handshake and the status
// lines.
interface sdu_mem_dump_if;
  logic        start;
  logic [31:0] start_addr;
  logic [10:0] word_cnt;
  logic [31:0] addr_sdu;
  logic [31:0] data_sdu;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic        busy;
  logic        done;

  // Requester / memory / UART side
  modport master (
    output start, start_addr, word_cnt, data_sdu, tx_ready,
    input  addr_sdu, tx_data, tx_valid, busy, done
  );

  // Dump unit side
  modport slave (
    input  start, start_addr, word_cnt, data_sdu, tx_ready,
    output addr_sdu, tx_data, tx_valid, busy, done
  );
endinterface

// File: rtl/sdu_mem_dump.sv
// Memory dump unit. It reads words from data memory over a debug port and
// streams each word as 8 uppercase hex ASCII characters, most significant
// nibble first, followed by a newline (0x0A). Transfers use a
// valid/ready byte handshake.
module sdu_mem_dump (
  input  logic clk,
  input  logic rst,
  sdu_mem_dump_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, SEND, NL, DONE} state_t;

  state_t      state_q, state_d;
  logic [9:0]  ptr;
  logic [10:0] remaining;
  logic [2:0]  nib;
  logic [31:0] word_reg;
  logic [3:0]  cur_nib;
  logic        hs;
  logic        unused_addr_hi;

  // Only a 1K-word window is addressable. The upper address bits are ignored.
  assign unused_addr_hi = |bus.start_addr[31:10];

  assign bus.tx_valid = (state_q == SEND) || (state_q == NL);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.addr_sdu = {22'b0, ptr};
  assign hs           = bus.tx_valid & bus.tx_ready;

  // nib counts characters sent, so character 0 is bits [31:28].
  assign cur_nib = word_reg[{3'd7 - nib, 2'b00} +: 4];

  // The hex character depends only on registered state. This keeps
  // tx_data stable while the UART stalls.
  always_comb begin
    bus.tx_data = 8'h00;
    if (state_q == SEND)
      bus.tx_data = (cur_nib < 4'd10) ? {4'h3, cur_nib} : 8'h37 + {4'h0, cur_nib};
    else if (state_q == NL)
      bus.tx_data = 8'h0A;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic. A start request is seen only in IDLE, so a start
  // that arrives while busy is dropped.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.start) state_d = (bus.word_cnt != 11'd0) ? LOAD : DONE;
      LOAD: state_d = SEND;
      SEND: if (hs && nib == 3'd7) state_d = NL;
      NL:   if (hs) state_d = (remaining == 11'd1) ? DONE : LOAD;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath: pointer, words-left counter, captured word, nibble index
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr       <= '0;
      remaining <= '0;
      nib       <= '0;
      word_reg  <= '0;
    end else begin
      case (state_q)
        IDLE: if (bus.start && bus.word_cnt != 11'd0) begin
          ptr       <= bus.start_addr[9:0];
          remaining <= (bus.word_cnt > 11'd1024) ? 11'd1024 : bus.word_cnt;
        end
        LOAD: begin
          word_reg <= bus.data_sdu;
          nib      <= '0;
        end
        SEND: if (hs) nib <= nib + 3'd1;
        NL: if (hs) begin
          ptr       <= ptr + 10'd1;  // natural 10-bit wrap 1023 -> 0
          remaining <= remaining - 11'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sdu_mem_dump.sv
// Testbench for sdu_mem_dump. A memory array feeds the debug read port.
// A queue model holds the expected (byte, address) stream. It is built from
// memory contents using a hex string lookup, and a per-cycle monitor checks
// handshakes, stall stability and done timing against it.
module tb_sdu_mem_dump;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdu_mem_dump_if bus ();
  sdu_mem_dump dut (.clk(clk), .rst(rst), .bus(bus));

  logic [31:0] mem [1024];
  assign bus.data_sdu = mem[bus.addr_sdu[9:0]];

  typedef struct packed { logic [7:0] b; logic [9:0] a; } exp_t;
  exp_t        exp_q[$];
  logic [7:0]  got_q[$];
  exp_t        e_cur;
  string       hexs = "0123456789ABCDEF";

  int checks = 0, errors = 0;
  int nbytes = 0, ndone = 0, cyc = 0, start_cyc = 0, first_lat = -1;
  int stall_left = 0, rdy_mode = 0;
  bit seen_first = 0, done_exp = 0;
  logic prev_v = 0, prev_rdy = 0;
  logic [7:0] prev_d = 0;

  logic [7:0] lit030 [9] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h0A};
  logic [7:0] lit031 [18] = '{8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h46, 8'h0A,
                              8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h0A};

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // UART ready: a forced stall window takes priority, then random or always-ready
  initial begin
    bus.tx_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (stall_left > 0) begin
        bus.tx_ready = 1'b0;
        stall_left--;
      end else if (rdy_mode == 1) bus.tx_ready = 1'($urandom_range(0, 1));
      else bus.tx_ready = 1'b1;
    end
  end

  // Per-cycle monitor. It samples at negedge, and inputs change only just after posedge.
  always @(negedge clk) begin
    if (rst) begin
      prev_v   = 1'b0;
      done_exp = 1'b0;
    end else begin
      chk("done_pulse", bus.done, done_exp);
      done_exp = 1'b0;
      if (prev_v && !prev_rdy) begin
        chk("stall_hold_valid", bus.tx_valid, 1);
        chk("stall_hold_data", bus.tx_data, prev_d);
      end
      if (bus.tx_valid && !seen_first) begin
        seen_first = 1;
        first_lat  = cyc - start_cyc;
      end
      if (bus.tx_valid && bus.tx_ready) begin
        nbytes++;
        got_q.push_back(bus.tx_data);
        chk("byte_expected", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e_cur = exp_q.pop_front();
          chk("tx_data", bus.tx_data, e_cur.b);
          chk("addr_sdu", bus.addr_sdu, {22'b0, e_cur.a});
          if (exp_q.size() == 0) done_exp = 1'b1;
        end
      end
      if (bus.done) ndone++;
      prev_v   = bus.tx_valid;
      prev_rdy = bus.tx_ready;
      prev_d   = bus.tx_data;
    end
  end

  task automatic push_exp(int sa, int cnt);
    int n;
    int addr;
    logic [31:0] w;
    n = (cnt > 1024) ? 1024 : cnt;
    for (int i = 0; i < n; i++) begin
      addr = (sa + i) % 1024;
      w = mem[addr];
      for (int k = 7; k >= 0; k--) exp_q.push_back('{b: hexs[w[4*k +: 4]], a: addr[9:0]});
      exp_q.push_back('{b: 8'h0A, a: addr[9:0]});
    end
  endtask

  task automatic start_dump(int sa, int cnt);
    push_exp(sa, cnt);
    seen_first = 0;
    @(posedge clk); #1;
    bus.start_addr = sa;
    bus.word_cnt   = cnt[10:0];
    bus.start      = 1'b1;
    start_cyc      = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
    if (cnt == 0) done_exp = 1'b1;
  endtask

  task automatic wait_idle(string name, int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.busy || exp_q.size() != 0) && n < budget);
    chk({name, "_timeout"}, n < budget, 1);
    @(negedge clk);
  endtask

  task automatic wait_bytes(int target, int budget);
    int n;
    n = 0;
    while (nbytes < target && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_bytes_timeout", nbytes >= target, 1);
  endtask

  int b0, d0;

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.start_addr = '0;
    bus.word_cnt = '0;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_tx_valid", bus.tx_valid, 0);
    chk("rst_tx_data", bus.tx_data, 0);
    chk("rst_addr", bus.addr_sdu, 0);
    @(posedge clk); #1 rst = 1'b0;

    // Single word, literal byte stream and latency
    mem[5] = 32'h1234ABCD;
    got_q.delete(); b0 = nbytes; d0 = ndone;
    start_dump(5, 1);
    wait_idle("single", 200);
    chk("single_latency", first_lat, 2);
    chk("single_nbytes", nbytes - b0, 9);
    chk("single_ndone", ndone - d0, 1);
    chk("single_busy_after", bus.busy, 0);
    for (int i = 0; i < 9; i++) chk("single_literal", got_q[i], lit030[i]);

    // Address wrap 1023 -> 0
    mem[1023] = 32'hFFFFFFFF; mem[0] = 32'h0;
    got_q.delete(); b0 = nbytes; d0 = ndone;
    start_dump(1023, 2);
    wait_idle("wrap", 300);
    chk("wrap_nbytes", nbytes - b0, 18);
    chk("wrap_ndone", ndone - d0, 1);
    for (int i = 0; i < 18; i++) chk("wrap_literal", got_q[i], lit031[i]);

    // Stall mid-word, then random backpressure
    mem[200] = 32'hDEADBEEF; mem[201] = 32'h0F1E2D3C; mem[202] = 32'h89ABCDEF;
    b0 = nbytes; d0 = ndone;
    start_dump(200, 3);
    wait_bytes(b0 + 3, 100);
    stall_left = 5;
    rdy_mode = 1;
    wait_idle("stall", 1000);
    rdy_mode = 0;
    chk("stall_nbytes", nbytes - b0, 27);
    chk("stall_ndone", ndone - d0, 1);

    // Zero-length request
    b0 = nbytes; d0 = ndone;
    start_dump(16, 0);
    wait_idle("zero", 50);
    chk("zero_ndone", ndone - d0, 1);
    chk("zero_no_valid", seen_first, 0);
    chk("zero_nbytes", nbytes - b0, 0);

    // A start pulsed while busy is dropped
    mem[300] = 32'h00C0FFEE; mem[301] = 32'h7A5B3C91;
    b0 = nbytes; d0 = ndone;
    start_dump(300, 2);
    wait_bytes(b0 + 5, 100);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.start_addr = 7; bus.word_cnt = 5;
    @(posedge clk); #1 bus.start = 1'b0;
    wait_idle("ignore", 300);
    repeat (20) @(negedge clk);
    chk("ignore_nbytes", nbytes - b0, 18);
    chk("ignore_ndone", ndone - d0, 1);

    // Reset mid-dump, then a fresh dump behaves as from power-up
    mem[400] = 32'h11112222; mem[401] = 32'h33334444; mem[402] = 32'h55556666;
    b0 = nbytes; d0 = ndone;
    start_dump(400, 3);
    wait_bytes(b0 + 4, 100);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_tx_valid", bus.tx_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_addr", bus.addr_sdu, 0);
    exp_q.delete();
    @(posedge clk); #1 rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort_no_done", ndone - d0, 0);
    got_q.delete(); b0 = nbytes; d0 = ndone;
    start_dump(5, 1);
    wait_idle("redo", 200);
    chk("redo_latency", first_lat, 2);
    chk("redo_nbytes", nbytes - b0, 9);
    chk("redo_ndone", ndone - d0, 1);
    for (int i = 0; i < 9; i++) chk("redo_literal", got_q[i], lit030[i]);

    // Oversized count clamps to 1024 words
    for (int i = 0; i < 1024; i++) mem[i] = (i * 32'h01010101) ^ 32'hA5C30000;
    b0 = nbytes; d0 = ndone;
    start_dump(0, 2000);
    wait_idle("clamp", 12000);
    chk("clamp_nbytes", nbytes - b0, 9216);
    chk("clamp_ndone", ndone - d0, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
